// File: rtl/openframe_pad_cfg_ctrl.sv
// Wishbone-programmable pad configuration bank for the openframe GPIO ring.
// Shadow writes take effect only through a holdover-protected apply sequence.
module openframe_pad_cfg_ctrl #(
    parameter int          NUM_PADS    = 44,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          HOLD_CYCLES = 4,
    parameter logic [2:0]  RESET_DM    = 3'b001
) (
    input  logic                wb_clk_i,
    input  logic                wb_rstn_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic [31:0]         wbs_dat_o,
    output logic                wbs_ack_o,
    input  logic [NUM_PADS-1:0] core_oeb_i,
    output logic [NUM_PADS-1:0] gpio_oeb,
    output logic [NUM_PADS-1:0] gpio_dm2,
    output logic [NUM_PADS-1:0] gpio_dm1,
    output logic [NUM_PADS-1:0] gpio_dm0,
    output logic [NUM_PADS-1:0] gpio_inp_dis,
    output logic [NUM_PADS-1:0] gpio_ib_mode_sel,
    output logic [NUM_PADS-1:0] gpio_vtrip_sel,
    output logic [NUM_PADS-1:0] gpio_slow_sel,
    output logic [NUM_PADS-1:0] gpio_analog_en,
    output logic [NUM_PADS-1:0] gpio_analog_sel,
    output logic [NUM_PADS-1:0] gpio_analog_pol,
    output logic [NUM_PADS-1:0] gpio_holdover,
    output logic                cfg_busy_o,
    output logic                cfg_done_o
);

    localparam int             CW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [11:0]    PAD_RST  = {9'd0, RESET_DM};
    localparam logic [5:0]     CSR_IDX  = 6'h3F;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_LOAD   = 2'd2;
    localparam logic [1:0] S_SETTLE = 2'd3;

    logic [11:0]   shadow_q [NUM_PADS];
    logic [11:0]   active_q [NUM_PADS];
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pending_q, pending_d;
    logic          ack_q;
    logic [31:0]   dat_q;

    logic          wb_req, addr_hit, pad_hit, csr_hit, apply_wr, load_en, busy;
    logic [5:0]    word_idx;
    logic [31:0]   rd_data;

    assign wb_req   = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign addr_hit = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign word_idx = wbs_adr_i[7:2];
    assign pad_hit  = addr_hit && ({1'b0, word_idx} < 7'(NUM_PADS));
    assign csr_hit  = addr_hit && (word_idx == CSR_IDX);
    assign apply_wr = wb_req & wbs_we_i & csr_hit & wbs_sel_i[0] & wbs_dat_i[0];
    assign busy     = (state_q != S_IDLE);

    always_comb begin
        rd_data = '0;
        if (pad_hit) begin
            rd_data = {20'd0, shadow_q[word_idx]};
        end else if (csr_hit) begin
            rd_data = {30'd0, busy, pending_q};
        end
    end

    // A request arriving while leaving IDLE is cleared here: that sequence consumes it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q | apply_wr;
        load_en   = 1'b0;
        cfg_done_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    state_d   = S_HOLD;
                    cnt_d     = CNT_LOAD;
                    pending_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) state_d = S_LOAD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_LOAD: begin
                load_en = 1'b1;
                state_d = S_SETTLE;
                cnt_d   = CNT_LOAD;
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d    = S_IDLE;
                    cfg_done_o = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            ack_q     <= wb_req;
            if (wb_req) dat_q <= wbs_we_i ? 32'd0 : rd_data;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                shadow_q[i] <= PAD_RST;
                active_q[i] <= PAD_RST;
            end
        end else begin
            if (wb_req && wbs_we_i && pad_hit) begin
                if (wbs_sel_i[0]) shadow_q[word_idx][7:0]  <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) shadow_q[word_idx][11:8] <= wbs_dat_i[11:8];
            end
            if (load_en) begin
                for (int i = 0; i < NUM_PADS; i++) active_q[i] <= shadow_q[i];
            end
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;
    assign cfg_busy_o = busy;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
            assign gpio_dm0[gi]         = active_q[gi][0];
            assign gpio_dm1[gi]         = active_q[gi][1];
            assign gpio_dm2[gi]         = active_q[gi][2];
            assign gpio_inp_dis[gi]     = active_q[gi][3];
            assign gpio_ib_mode_sel[gi] = active_q[gi][4];
            assign gpio_vtrip_sel[gi]   = active_q[gi][5];
            assign gpio_slow_sel[gi]    = active_q[gi][6];
            assign gpio_analog_en[gi]   = active_q[gi][7];
            assign gpio_analog_sel[gi]  = active_q[gi][8];
            assign gpio_analog_pol[gi]  = active_q[gi][9];
            assign gpio_oeb[gi]         = active_q[gi][10] ? active_q[gi][11] : core_oeb_i[gi];
            assign gpio_holdover[gi]    = busy;
        end
    endgenerate

    // Address byte lanes, upper selects and upper data bits carry no register state.
    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:12]};

endmodule

// File: tb/tb_openframe_pad_cfg_ctrl.sv
// Scoreboard-driven bench for openframe_pad_cfg_ctrl: bus readback, apply timing, reset.
module tb_openframe_pad_cfg_ctrl;
    localparam int          NP   = 44;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] CSR  = BASE + 32'h0000_00FC;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cyc, stb, we;
    logic [3:0]    sel;
    logic [31:0]   adr, wdat, dat_o;
    logic          ack;
    logic [NP-1:0] core_oeb, oeb, dm2, dm1, dm0, inp_dis, ib_mode, vtrip, slow;
    logic [NP-1:0] an_en, an_sel, an_pol, holdover;
    logic          busy, done;

    int            n_total = 0;
    int            n_bad   = 0;
    logic [31:0]   exp_q[$];

    openframe_pad_cfg_ctrl dut (
        .wb_clk_i(clk), .wb_rstn_i(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
        .core_oeb_i(core_oeb), .gpio_oeb(oeb),
        .gpio_dm2(dm2), .gpio_dm1(dm1), .gpio_dm0(dm0),
        .gpio_inp_dis(inp_dis), .gpio_ib_mode_sel(ib_mode),
        .gpio_vtrip_sel(vtrip), .gpio_slow_sel(slow),
        .gpio_analog_en(an_en), .gpio_analog_sel(an_sel), .gpio_analog_pol(an_pol),
        .gpio_holdover(holdover), .cfg_busy_o(busy), .cfg_done_o(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] pad_dm(input int p);
        return {dm2[p], dm1[p], dm0[p]};
    endfunction

    // One bus transaction followed by one idle cycle; returns at posedge+1.
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rdat, output int lat);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack && lat < 10);
        if (!ack) chk("ack_timeout", 64'd0, 64'd1);
        rdat = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("ack_drop", 64'(ack), 64'd0);
        $display("bus %s adr=0x%08h dat=0x%08h sel=%b lat=%0d", w ? "wr" : "rd", a, w ? d : rdat, s, lat);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int lat);
        logic [31:0] r;
        bus(1'b1, a, d, s, r, lat);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp, output int lat);
        logic [31:0] r;
        exp_q.push_back(exp);
        bus(1'b0, a, 32'd0, 4'hF, r, lat);
        chk(tag, 64'(r), 64'(exp_q.pop_front()));
    endtask

    // Samples once per cycle starting now; cycle 0 is the current cycle.
    task automatic watch(input int n, input int pad, input logic [2:0] dmexp,
                         output int hcnt, output int rises, output int h0, output int dcnt,
                         output int chg, output int oeb_chg, output int mism);
        logic prev;
        prev = 1'b0; hcnt = 0; rises = 0; h0 = -1; dcnt = 0; chg = -1; oeb_chg = -1; mism = 0;
        for (int i = 0; i < n; i++) begin
            if (holdover[0]) hcnt++;
            if (holdover[0] && !prev) rises++;
            if (holdover[0] && h0 < 0) h0 = i;
            prev = holdover[0];
            if (done) dcnt++;
            if (chg < 0 && pad_dm(pad) == dmexp) chg = i;
            if (oeb_chg < 0 && oeb[pad]) oeb_chg = i;
            if (busy !== holdover[0] || holdover !== {NP{holdover[0]}}) mism++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int lat, hcnt, rises, h0, dcnt, chg, oeb_chg, mism;
        logic [NP-1:0] ones;
        ones = '1;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
        core_oeb = NP'({$urandom, $urandom});
        core_oeb[3] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        chk("rst_dm0", 64'(dm0), 64'(ones));
        chk("rst_dm1", 64'(dm1), 64'd0);
        chk("rst_dm2", 64'(dm2), 64'd0);
        chk("rst_misc", 64'(|{inp_dis, ib_mode, vtrip, slow, an_en, an_sel, an_pol}), 64'd0);
        chk("rst_holdover", 64'(holdover), 64'd0);
        chk("rst_oeb", 64'(oeb), 64'(core_oeb));
        chk("rst_busy", 64'(busy), 64'd0);
        rd("rst_pad5", BASE + 32'h14, 32'h001, lat);
        rd("rst_csr", CSR, 32'h0, lat);

        // Shadow write does not touch pads until applied
        wr(BASE + 32'h0C, 32'h0000_0C06, 4'b0011, lat);
        rd("pad3_shadow", BASE + 32'h0C, 32'h0C06, lat);
        chk("pad3_dm_preapply", 64'(pad_dm(3)), 64'(3'b001));
        chk("pad3_oeb_preapply", 64'(oeb[3]), 64'd0);
        wr(CSR, 32'h1, 4'hF, lat);
        watch(14, 3, 3'b110, hcnt, rises, h0, dcnt, chg, oeb_chg, mism);
        chk("apply_h0", 64'(h0), 64'd0);
        chk("apply_hcnt", 64'(hcnt), 64'd9);
        chk("apply_rises", 64'(rises), 64'd1);
        chk("apply_dm_cycle", 64'(chg), 64'd5);
        chk("apply_oeb_cycle", 64'(oeb_chg), 64'd5);
        chk("apply_done", 64'(dcnt), 64'd1);
        chk("apply_busy_hold", 64'(mism), 64'd0);

        // Byte selects
        wr(BASE + 32'h00, 32'h0000_0FFF, 4'b0011, lat);
        rd("pad0_full", BASE + 32'h00, 32'h0FFF, lat);
        wr(BASE + 32'h00, 32'h0000_00FF, 4'b0001, lat);
        rd("pad0_sel0", BASE + 32'h00, 32'h0FFF, lat);
        wr(BASE + 32'h00, 32'h0000_0000, 4'b0010, lat);
        rd("pad0_sel1", BASE + 32'h00, 32'h00FF, lat);

        // Requests while busy coalesce; HOLD-time shadow write reaches LOAD
        wr(BASE + 32'h04, 32'h0000_0002, 4'hF, lat);
        wr(CSR, 32'h1, 4'hF, lat);
        fork
            watch(30, 1, 3'b111, hcnt, rises, h0, dcnt, chg, oeb_chg, mism);
            begin
                int l2;
                wr(CSR, 32'h1, 4'hF, l2);
                wr(BASE + 32'h04, 32'h0000_0007, 4'hF, l2);
                wr(CSR, 32'h1, 4'hF, l2);
                wr(CSR, 32'h1, 4'hF, l2);
            end
        join
        chk("coal_rises", 64'(rises), 64'd2);
        chk("coal_hcnt", 64'(hcnt), 64'd18);
        chk("coal_done", 64'(dcnt), 64'd2);
        chk("coal_load_pickup", 64'(chg), 64'd5);
        chk("coal_busy_hold", 64'(mism), 64'd0);
        rd("coal_csr_idle", CSR, 32'h0, lat);

        // Unmapped accesses
        wr(BASE + 32'(4 * NP), 32'h0000_0FFF, 4'hF, lat);
        chk("unmap_wr_lat", 64'(lat), 64'd1);
        rd("unmap_end", BASE + 32'(4 * NP), 32'h0, lat);
        chk("unmap_rd_lat", 64'(lat), 64'd1);
        wr(32'h0000_0080, 32'h0000_0FFF, 4'hF, lat);
        rd("unmap_0x80", 32'h0000_0080, 32'h0, lat);
        rd("pad32_intact", BASE + 32'h80, 32'h001, lat);
        rd("pad3_intact", BASE + 32'h0C, 32'h0C06, lat);

        // Asynchronous reset in the LOAD cycle
        wr(BASE + 32'h08, 32'h0000_0380, 4'hF, lat);
        wr(CSR, 32'h1, 4'hF, lat);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_holdover", 64'(holdover), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_dm0", 64'(dm0), 64'(ones));
        chk("arst_dm21", 64'(dm2 | dm1), 64'd0);
        chk("arst_analog", 64'(an_en | an_sel | an_pol), 64'd0);
        chk("arst_oeb", 64'(oeb), 64'(core_oeb));
        chk("arst_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd("arst_pad3", BASE + 32'h0C, 32'h001, lat);
        rd("arst_pad2", BASE + 32'h08, 32'h001, lat);
        repeat (12) @(posedge clk);
        #1;
        chk("arst_stays_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
